// File: rtl/jtopl_wrq.sv
// Write queue and sequencer in front of the OPL register interface: buffers (register, value)
// pairs and replays each as an address-port write then a data-port write, honouring busy times.
module jtopl_wrq #(
    parameter int unsigned AW        = 3,
    parameter int unsigned ADDR_WAIT = 4,
    parameter int unsigned DATA_WAIT = 24
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          push,
    input  logic [7:0]    push_reg,
    input  logic [7:0]    push_val,
    input  logic          flush,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          lost,
    output logic          busy,
    output logic          write,
    output logic          addr,
    output logic [7:0]    dout
);

    localparam int unsigned Depth   = 2 ** AW;
    localparam int unsigned MaxWait = (ADDR_WAIT > DATA_WAIT) ? ADDR_WAIT : DATA_WAIT;
    localparam int unsigned CW      = (MaxWait > 0) ? $clog2(MaxWait + 1) : 1;

    typedef enum logic [1:0] {StIdle, StAddrWait, StDataWait} state_e;

    state_e          state_q, state_d;
    logic [15:0]     mem_q [Depth];
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]     level_q, level_d;
    logic            full_q, full_d, empty_q, empty_d, lost_q, lost_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [7:0]      hold_val_q, hold_val_d;
    logic            write_q, write_d, addr_q, addr_d, busy_q, busy_d;
    logic [7:0]      dout_q, dout_d;
    logic            push_ok, pop;
    logic [15:0]     head;

    assign head    = mem_q[rd_ptr_q];
    assign push_ok = push & ~full_q & ~flush;
    // A flush on the same edge discards the head instead of issuing it.
    assign pop     = (state_q == StIdle) & ~empty_q & ~flush;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        hold_val_d = hold_val_q;
        write_d    = 1'b0;
        addr_d     = addr_q;
        dout_d     = dout_q;
        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    hold_val_d = head[7:0];
                    write_d    = 1'b1;
                    addr_d     = 1'b0;
                    dout_d     = head[15:8];
                    cnt_d      = CW'(ADDR_WAIT);
                    state_d    = StAddrWait;
                end
            end
            StAddrWait: begin
                if (cnt_q == '0) begin
                    write_d = 1'b1;
                    addr_d  = 1'b1;
                    dout_d  = hold_val_q;
                    cnt_d   = CW'(DATA_WAIT);
                    state_d = StDataWait;
                end else if (cen) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            StDataWait: begin
                if (cnt_q == '0) begin
                    state_d = StIdle;
                end else if (cen) begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    always_comb begin
        wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
        level_d  = level_q;
        if (push_ok && !pop) begin
            level_d = level_q + 1'b1;
        end else if (!push_ok && pop) begin
            level_d = level_q - 1'b1;
        end
        // A dropped push marks loss even when a pop frees a slot on the same edge.
        lost_d = lost_q | (push & full_q);
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            lost_d   = 1'b0;
        end
        full_d  = (level_d == (AW + 1)'(Depth));
        empty_d = (level_d == '0);
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= {push_reg, push_val};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            full_q     <= 1'b0;
            empty_q    <= 1'b1;
            lost_q     <= 1'b0;
            cnt_q      <= '0;
            hold_val_q <= '0;
            write_q    <= 1'b0;
            addr_q     <= 1'b0;
            busy_q     <= 1'b0;
            dout_q     <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            full_q     <= full_d;
            empty_q    <= empty_d;
            lost_q     <= lost_d;
            cnt_q      <= cnt_d;
            hold_val_q <= hold_val_d;
            write_q    <= write_d;
            addr_q     <= addr_d;
            busy_q     <= busy_d;
            dout_q     <= dout_d;
        end
    end

    assign full  = full_q;
    assign empty = empty_q;
    assign level = level_q;
    assign lost  = lost_q;
    assign busy  = busy_q;
    assign write = write_q;
    assign addr  = addr_q;
    assign dout  = dout_q;

endmodule

// File: tb/tb_jtopl_wrq.sv
// Bench for jtopl_wrq: queue-based reference model compared every cycle, directed scenarios with
// literal expectations, a zero-wait instance for back-to-back strobes, then randomized traffic.
module tb_jtopl_wrq;

    localparam int AWAIT = 4;
    localparam int DWAIT = 24;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst = 1'b1, cen = 1'b0, push = 1'b0, flush = 1'b0;
    logic [7:0] push_reg = 8'h00, push_val = 8'h00;
    logic       full, empty, lost, busy, write, addr;
    logic [3:0] level;
    logic [7:0] dout;

    logic       push0 = 1'b0;
    logic [7:0] push_reg0 = 8'h00, push_val0 = 8'h00;
    logic       full0, empty0, lost0, busy0, write0, addr0;
    logic [3:0] level0;
    logic [7:0] dout0;

    jtopl_wrq u_dut (
        .clk(clk), .rst(rst), .cen(cen), .push(push), .push_reg(push_reg),
        .push_val(push_val), .flush(flush), .full(full), .empty(empty), .level(level),
        .lost(lost), .busy(busy), .write(write), .addr(addr), .dout(dout)
    );

    jtopl_wrq #(.AW(3), .ADDR_WAIT(0), .DATA_WAIT(0)) u_dut0 (
        .clk(clk), .rst(rst), .cen(1'b1), .push(push0), .push_reg(push_reg0),
        .push_val(push_val0), .flush(1'b0), .full(full0), .empty(empty0), .level(level0),
        .lost(lost0), .busy(busy0), .write(write0), .addr(addr0), .dout(dout0)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            if (n_fail <= 30) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference model: FIFO as a queue, sequencer as a phase plus remaining cen ticks.
    logic [15:0] mq[$];
    int          m_phase = 0;  // 0 idle, 1 waiting after address write, 2 after data write
    int          m_left  = 0;
    logic [7:0]  m_hval  = 8'h00;
    logic        m_write = 1'b0, m_addr = 1'b0, m_lost = 1'b0;
    logic [7:0]  m_dout  = 8'h00;
    bit          m_valid = 1'b0;

    initial begin
        forever begin
            int          sz;
            logic [15:0] h;
            @(posedge clk);
            if (rst) begin
                mq.delete();
                m_phase = 0; m_left = 0; m_write = 1'b0; m_addr = 1'b0;
                m_dout = 8'h00; m_lost = 1'b0; m_valid = 1'b1;
            end else begin
                sz = mq.size();
                m_write = 1'b0;
                if (m_phase == 0) begin
                    if (sz != 0 && !flush) begin
                        h = mq.pop_front();
                        m_hval = h[7:0];
                        m_write = 1'b1; m_addr = 1'b0; m_dout = h[15:8];
                        m_left = AWAIT; m_phase = 1;
                    end
                end else if (m_left == 0) begin
                    if (m_phase == 1) begin
                        m_write = 1'b1; m_addr = 1'b1; m_dout = m_hval;
                        m_left = DWAIT; m_phase = 2;
                    end else begin
                        m_phase = 0;
                    end
                end else if (cen) begin
                    m_left--;
                end
                if (flush) begin
                    mq.delete();
                    m_lost = 1'b0;
                end else if (push) begin
                    if (sz == 8) m_lost = 1'b1;
                    else mq.push_back({push_reg, push_val});
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("write", write, m_write);
                chk("addr", addr, m_addr);
                chk("dout", dout, m_dout);
                chk("level", level, mq.size());
                chk("full", full, mq.size() == 8);
                chk("empty", empty, mq.size() == 0);
                chk("lost", lost, m_lost);
                chk("busy", busy, m_phase != 0);
            end
        end
    end

    // Strobe logs: {addr, dout} for the main DUT, edge index plus data for the zero-wait DUT.
    logic [8:0] sq[$];
    logic [8:0] sq0[$];
    int         sq0_cyc[$];
    int         cyc = 0;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            #1;
            if (write) sq.push_back({addr, dout});
            if (write0) begin
                sq0.push_back({addr0, dout0});
                sq0_cyc.push_back(cyc);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; push = 1'b0; flush = 1'b0; push0 = 1'b0;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((busy || !empty) && n < 2000) begin
            tick();
            n++;
        end
        chk(nm, {busy, empty}, 2'b01);
    endtask

    int         a_e, d_e, i_e, nw, ta, td, n, c0;
    logic       lastcen;
    logic [7:0] er, ev;
    int         offs[6];

    initial begin
        do_reset();

        // Single push, cen on every second clock.
        sq.delete();
        cen = 1'b0; push = 1'b1; push_reg = 8'hA0; push_val = 8'h44;
        tick();
        push = 1'b0;
        a_e = -1; d_e = -1; i_e = -1; nw = 0; ta = 0; td = 0; lastcen = 1'b0;
        for (int i = 1; i < 400 && i_e < 0; i++) begin
            cen = i[0];
            tick();
            if (write) begin
                nw++;
                if (!addr) begin
                    a_e = i;
                    chk("t1 addr strobe dout", dout, 8'hA0);
                end else begin
                    d_e = i;
                    chk("t1 data strobe dout", dout, 8'h44);
                    chk("t1 cen ticks before data", ta, 4);
                    chk("t1 tick on edge before data", lastcen, 1'b1);
                end
            end else if (a_e >= 0 && d_e < 0) begin
                if (cen) ta++;
            end else if (d_e >= 0 && busy) begin
                if (cen) td++;
            end
            if (d_e >= 0 && !busy) begin
                i_e = i;
                chk("t1 cen ticks before idle", td, 24);
                chk("t1 tick on edge before idle", lastcen, 1'b1);
            end
            lastcen = cen;
        end
        chk("t1 address strobe on first edge", a_e, 1);
        chk("t1 reached idle", i_e > 0, 1'b1);
        chk("t1 write pulses", nw, 2);

        // Ten back-to-back pushes from idle; the first goes in flight.
        do_reset();
        sq.delete();
        cen = 1'b1;
        for (int k = 0; k < 10; k++) begin
            push = 1'b1; push_reg = 8'h10 + 8'(k); push_val = 8'h80 + 8'(k);
            tick();
            if (k == 8) begin
                chk("t2 level at full", level, 4'd8);
                chk("t2 full", full, 1'b1);
                chk("t2 no loss yet", lost, 1'b0);
            end
            if (k == 9) begin
                chk("t2 lost on 10th", lost, 1'b1);
                chk("t2 level still 8", level, 4'd8);
            end
        end
        push = 1'b0;
        wait_idle("t2 drain");
        chk("t2 strobe count", sq.size(), 18);
        for (int k = 0; k < 9 && 2 * k + 1 < sq.size(); k++) begin
            er = 8'h10 + 8'(k);
            ev = 8'h80 + 8'(k);
            chk("t2 addr strobe", sq[2*k], {1'b0, er});
            chk("t2 data strobe", sq[2*k+1], {1'b1, ev});
        end

        // Flush during the data wait with five entries queued.
        do_reset();
        sq.delete();
        cen = 1'b1;
        for (int k = 0; k < 6; k++) begin
            push = 1'b1; push_reg = 8'h30 + 8'(k); push_val = 8'hC0 + 8'(k);
            tick();
        end
        push = 1'b0;
        n = 0;
        while (sq.size() < 2 && n < 200) begin
            tick();
            n++;
        end
        chk("t3 data strobe seen", sq.size(), 2);
        chk("t3 level before flush", level, 4'd5);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t3 level after flush", level, 4'd0);
        chk("t3 empty after flush", empty, 1'b1);
        chk("t3 lost after flush", lost, 1'b0);
        chk("t3 still busy", busy, 1'b1);
        repeat (60) tick();
        chk("t3 no further strobes", sq.size(), 2);
        chk("t3 idle", busy, 1'b0);

        // Zero-wait instance: three entries give A,D,gap,A,D,gap,A,D.
        sq0.delete();
        sq0_cyc.delete();
        c0 = cyc;
        for (int k = 0; k < 3; k++) begin
            push0 = 1'b1; push_reg0 = 8'h20 + 8'(k); push_val0 = 8'h90 + 8'(k);
            tick();
        end
        push0 = 1'b0;
        repeat (15) tick();
        offs = '{0, 1, 3, 4, 6, 7};
        chk("t4 strobe count", sq0.size(), 6);
        if (sq0_cyc.size() > 0) chk("t4 first strobe edge", sq0_cyc[0], c0 + 2);
        for (int k = 0; k < 6 && k < sq0.size(); k++) begin
            er = 8'h20 + 8'(k / 2);
            ev = 8'h90 + 8'(k / 2);
            chk("t4 strobe edge", sq0_cyc[k] - sq0_cyc[0], offs[k]);
            chk("t4 strobe data", sq0[k], (k % 2 == 0) ? {1'b0, er} : {1'b1, ev});
        end

        // Reset while waiting after the address write.
        do_reset();
        cen = 1'b1;
        push = 1'b1; push_reg = 8'h33; push_val = 8'h55;
        tick();
        push = 1'b0;
        tick();
        chk("t5 address strobe", {write, addr, dout}, {2'b10, 8'h33});
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t5 write after reset", write, 1'b0);
        chk("t5 busy after reset", busy, 1'b0);
        chk("t5 empty after reset", empty, 1'b1);
        sq.delete();
        push = 1'b1; push_reg = 8'h5A; push_val = 8'hA5;
        tick();
        push = 1'b0;
        wait_idle("t5 drain");
        chk("t5 strobe count", sq.size(), 2);
        if (sq.size() == 2) begin
            chk("t5 replay addr", sq[0], {1'b0, 8'h5A});
            chk("t5 replay data", sq[1], {1'b1, 8'hA5});
        end

        // Push on the same edge as the idle pop keeps level at 1.
        do_reset();
        sq.delete();
        cen = 1'b1;
        push = 1'b1; push_reg = 8'h61; push_val = 8'h62;
        tick();
        chk("t6 level before pop", level, 4'd1);
        push_reg = 8'h71; push_val = 8'h72;
        tick();
        push = 1'b0;
        chk("t6 level after push+pop", level, 4'd1);
        chk("t6 first issued", {write, dout}, {1'b1, 8'h61});
        wait_idle("t6 drain");
        chk("t6 strobe count", sq.size(), 4);
        if (sq.size() == 4) chk("t6 next issued", sq[2], {1'b0, 8'h71});

        // Randomized traffic, checked every cycle against the model.
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            cen      = 1'($urandom_range(0, 1));
            push     = ($urandom_range(0, 7) < ((i / 500) % 2 == 0 ? 6 : 1));
            push_reg = 8'($urandom);
            push_val = 8'($urandom);
            flush    = ($urandom_range(0, 99) < 2);
            rst      = ($urandom_range(0, 599) == 0);
            tick();
        end
        rst = 1'b0; push = 1'b0; flush = 1'b0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
